reg_serializer: RTL and testbench
=================================

# reg_serializer

Parallel-in, serial-out transmitter that pairs with the enabled capture register (`register_v`). It accepts a WIDTH-bit word through a valid/ready load port and shifts it out LSB-first, one bit per accepted transfer, with downstream backpressure. It is the drive end of the serial link whose receive end assembles bits back into the 64-bit datapath registers.

## Interface
Parameters:
- `WIDTH`, 64, word length in bits; legal range is 2 to 64.

Ports:
- `clk`, in, 1, single clock; all state changes on the rising edge.
- `reset`, in, 1, asynchronous, active-low. 0 clears all state immediately, independent of `clk`.
- `load_valid`, in, 1, upstream has a word on `data_in`.
- `load_ready`, out, 1, block can accept a word this cycle.
- `data_in`, in, WIDTH, word to transmit.
- `ser_out`, out, 1, current serial bit.
- `ser_valid`, out, 1, `ser_out` is meaningful.
- `ser_last`, out, 1, the current bit is bit WIDTH-1 of the word.
- `ser_ready`, in, 1, downstream accepts the current bit this cycle.
- `busy`, out, 1, a word is in flight; equals the inverse of `load_ready`.

## Operation
- **State:** the block holds the following:
  - FSM with states IDLE and SHIFT.
  - Shift register `shadow` of WIDTH bits.
  - Bit counter `cnt` of ceil(log2(WIDTH)) bits.
- **Reset** (while `reset`=0, asynchronous):
  - State forced to IDLE, `shadow`=0, `cnt`=0.
  - Outputs: `load_ready`=1, `busy`=0, `ser_valid`=0, `ser_last`=0, `ser_out`=0.
- **IDLE:**
  - `load_ready`=1 and `ser_valid`=0. `ser_out` and `ser_last` are held at 0.
  - When `load_valid`=1 at a rising edge:
    - `shadow` is loaded with `data_in`.
    - `cnt` is set to 0.
    - The FSM moves to SHIFT.
  - When `load_valid`=0, the state is held.
- **SHIFT:**
  - `load_ready`=0 and `ser_valid`=1.
  - `ser_out`=`shadow[0]`.
  - `ser_last`=1 exactly when `cnt`==WIDTH-1.
  - When `ser_ready`=1 at an edge:
    - `shadow` shifts right by one, with a 0 inserted at the MSB.
    - `cnt` increments.
    - If `ser_last` was 1, the FSM returns to IDLE and `cnt` is cleared to 0.
  - When `ser_ready`=0, `shadow`, `cnt`, the state and all outputs hold.
  - A bit is considered transferred only on an edge where `ser_valid` and `ser_ready` are both 1.
- **Ignored loads:** `load_valid` in SHIFT is ignored. `data_in` is sampled only on the accepting edge, and later changes to it do not affect the word in flight.
- **Outputs:** all outputs are decoded from registered state only. There is no combinational path from any input to any output.
- **Counter width:** `cnt` never exceeds WIDTH-1 and has no wrap-around case. The WIDTH-1 compare is done at full counter width.

## Timing
- **Load latency:** a word accepted at edge k puts bit 0 on `ser_out` with `ser_valid`=1 in the cycle after edge k.
- **Word throughput:** with `ser_ready` held at 1, each word occupies exactly WIDTH SHIFT cycles plus 1 IDLE cycle. A new word is therefore accepted every WIDTH+1 cycles; the single bubble is required.
- **Stalls:** each cycle with `ser_ready`=0 in SHIFT extends the word by exactly one cycle.
- **Last bit:** `ser_last` is high for the whole final-bit cycle, including any stall cycles on that bit.
- **Reset mid-word:** asserting `reset` during SHIFT aborts the word immediately, with no further bits sent. After release, the block sits in IDLE with `load_ready`=1 starting from the first edge after deassertion.
- **Reset release:** deassertion is presented synchronously to `clk` by the system. The block performs no internal synchronization.

## Test plan
- **Reset values:** with WIDTH=8, hold `reset`=0 for 3 cycles, then release. Required: `load_ready`=1, `busy`=0, and `ser_valid`, `ser_out`, `ser_last` all 0 throughout.
- **Basic word:** with WIDTH=8 and `ser_ready`=1, load 8'hA5. Required:
  - `ser_out` sequence is 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - `ser_last` is high only on the 8th cycle.
  - `load_ready` is 1 again on the 9th cycle.
- **Backpressure:** with WIDTH=8, load 8'h0F and drop `ser_ready` for 2 cycles during bit 3 and 1 cycle during bit 7. Required:
  - The bit stream is still 1,1,1,1,0,0,0,0.
  - `ser_out` is stable during each stall.
  - `ser_last` stays high through the bit-7 stall.
  - Total SHIFT cycles = 11.
- **Back-to-back loads:** with WIDTH=8, keep `load_valid`=1 and toggle `data_in` every cycle. Required:
  - Words are accepted every 9 cycles.
  - Each transmitted word matches the `data_in` value on its accepting edge.
  - Mid-word `data_in` changes are ignored.
- **Async abort:** with WIDTH=64, load 64'h8000_0000_0000_1388 and assert `reset` asynchronously between edges at bit 20. Required:
  - `ser_valid` drops immediately, without waiting for an edge.
  - After release, a new word 64'd1010 transmits correctly from bit 0.
- **Full-width boundary:** with WIDTH=64, load 64'hFFFF_FFFF_FFFF_FFFF. Required:
  - 64 ones are sent.
  - `ser_last` is high only on bit 63.
  - `cnt` returns to 0 and the FSM returns to IDLE after bit 63.

Source files
------------

// File: rtl/reg_serializer.sv
// Parallel-in, serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// load port and shifts it out LSB-first under downstream backpressure.
module reg_serializer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             load_ready_r;
    logic             busy_r;
    logic             ser_out_r;
    logic             ser_valid_r;
    logic             ser_last_r;
    logic             ser_out_s;
    logic             ser_last_s;

    // Next-state logic; outputs are precomputed from next state so they leave flops.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        cnt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (load_valid) begin
                    state_s  = SHIFT;
                    shadow_s = data_in;
                    cnt_s    = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (ser_ready) begin
                    shadow_s = {1'b0, shadow_r[WIDTH-1:1]};
                    if (cnt_r == CNT_LAST) begin
                        state_s = IDLE;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s  = IDLE;
                shadow_s = {WIDTH{1'b0}};
                cnt_s    = {CW{1'b0}};
            end
        endcase
        ser_out_s  = (state_s == SHIFT) ? shadow_s[0] : 1'b0;
        ser_last_s = (state_s == SHIFT) && (cnt_s == CNT_LAST);
    end

    // State, datapath and output registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            shadow_r     <= {WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            load_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            ser_out_r    <= 1'b0;
            ser_valid_r  <= 1'b0;
            ser_last_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            shadow_r     <= shadow_s;
            cnt_r        <= cnt_s;
            load_ready_r <= (state_s == IDLE);
            busy_r       <= (state_s == SHIFT);
            ser_out_r    <= ser_out_s;
            ser_valid_r  <= (state_s == SHIFT);
            ser_last_r   <= ser_last_s;
        end
    end

    assign load_ready = load_ready_r;
    assign busy       = busy_r;
    assign ser_out    = ser_out_r;
    assign ser_valid  = ser_valid_r;
    assign ser_last   = ser_last_r;

endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: an 8-bit and a 64-bit instance driven
// through reset, streaming, backpressure, back-to-back and async-abort scenarios.
module tb_reg_serializer;

    logic        clk;
    logic        rst8, lv8, sr8;
    logic [7:0]  din8;
    logic        lr8, so8, sv8, sl8, bz8;
    logic        rst64, lv64, sr64;
    logic [63:0] din64;
    logic        lr64, so64, sv64, sl64, bz64;

    int checks = 0;
    int errors = 0;

    reg_serializer #(.WIDTH(8)) d8 (
        .clk(clk), .reset(rst8), .load_valid(lv8), .load_ready(lr8),
        .data_in(din8), .ser_out(so8), .ser_valid(sv8), .ser_last(sl8),
        .ser_ready(sr8), .busy(bz8)
    );

    reg_serializer #(.WIDTH(64)) d64 (
        .clk(clk), .reset(rst64), .load_valid(lv64), .load_ready(lr64),
        .data_in(din64), .ser_out(so64), .ser_valid(sv64), .ser_last(sl64),
        .ser_ready(sr64), .busy(bz64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8(input string tag);
        check({tag, " lr8"}, 64'(lr8), 64'd1);
        check({tag, " bz8"}, 64'(bz8), 64'd0);
        check({tag, " sv8"}, 64'(sv8), 64'd0);
        check({tag, " so8"}, 64'(so8), 64'd0);
        check({tag, " sl8"}, 64'(sl8), 64'd0);
    endtask

    task automatic idle64(input string tag);
        check({tag, " lr64"}, 64'(lr64), 64'd1);
        check({tag, " bz64"}, 64'(bz64), 64'd0);
        check({tag, " sv64"}, 64'(sv64), 64'd0);
        check({tag, " so64"}, 64'(so64), 64'd0);
        check({tag, " sl64"}, 64'(sl64), 64'd0);
    endtask

    // Load a word into the 64-bit instance and check all bits with ser_ready high.
    task automatic send64(input string tag, input logic [63:0] w);
        lv64 = 1'b1; din64 = w; sr64 = 1'b1;
        step();
        lv64 = 1'b0; din64 = ~w;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("%s bit%0d out", tag, i), 64'(so64), 64'(w[i]));
            check($sformatf("%s bit%0d last", tag, i), 64'(sl64), 64'(i == 63));
            check($sformatf("%s bit%0d valid", tag, i), 64'(sv64), 64'd1);
            step();
        end
        idle64({tag, " end"});
    endtask

    initial begin
        logic [7:0]  w8;
        logic [63:0] w64;
        logic [7:0]  pat [0:26];
        int          shift_cycles;
        int          nstall;

        rst8 = 1'b0; lv8 = 1'b0; sr8 = 1'b1; din8 = 8'h00;
        rst64 = 1'b0; lv64 = 1'b0; sr64 = 1'b1; din64 = 64'd0;

        // Reset values held for three cycles, then after release.
        for (int c = 0; c < 3; c++) begin
            lv8 = 1'b1; din8 = 8'hFF;
            step();
            idle8($sformatf("rst c%0d", c));
            idle64($sformatf("rst c%0d", c));
        end
        lv8 = 1'b0;
        rst8 = 1'b1; rst64 = 1'b1;
        step();
        idle8("post-rst");

        // Basic word 8'hA5 -> 1,0,1,0,0,1,0,1.
        w8 = 8'hA5;
        lv8 = 1'b1; din8 = w8;
        step();
        lv8 = 1'b0; din8 = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("basic bit%0d out", i), 64'(so8), 64'(w8[i]));
            check($sformatf("basic bit%0d last", i), 64'(sl8), 64'(i == 7));
            check($sformatf("basic bit%0d lr", i), 64'(lr8), 64'd0);
            check($sformatf("basic bit%0d busy", i), 64'(bz8), 64'd1);
            step();
        end
        idle8("basic 9th");

        // Backpressure: 8'h0F with stalls of 2 on bit 3 and 1 on bit 7.
        w8 = 8'h0F;
        lv8 = 1'b1; din8 = w8;
        step();
        lv8 = 1'b0; din8 = 8'hF0;
        shift_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            nstall = (i == 3) ? 2 : ((i == 7) ? 1 : 0);
            for (int s = 0; s <= nstall; s++) begin
                sr8 = (s == nstall);
                check($sformatf("bp bit%0d s%0d out", i, s), 64'(so8), 64'(w8[i]));
                check($sformatf("bp bit%0d s%0d last", i, s), 64'(sl8), 64'(i == 7));
                if (sv8) shift_cycles++;
                step();
            end
        end
        sr8 = 1'b1;
        check("bp shift cycles", 64'(shift_cycles), 64'd11);
        idle8("bp end");

        // Back-to-back loads with data_in changing every cycle.
        for (int c = 0; c < 27; c++) pat[c] = 8'((c * 91) ^ 195);
        lv8 = 1'b1;
        for (int c = 0; c < 27; c++) begin
            din8 = pat[c];
            step();
            if (c == 26) lv8 = 1'b0;
            if ((c % 9) == 8) begin
                check($sformatf("b2b c%0d lr", c), 64'(lr8), 64'd1);
                check($sformatf("b2b c%0d valid", c), 64'(sv8), 64'd0);
            end else begin
                w8 = pat[c - (c % 9)];
                check($sformatf("b2b c%0d out", c), 64'(so8), 64'(w8[c % 9]));
                check($sformatf("b2b c%0d valid", c), 64'(sv8), 64'd1);
                check($sformatf("b2b c%0d last", c), 64'(sl8), 64'((c % 9) == 7));
            end
        end
        step();
        idle8("b2b end");

        // Async abort of a 64-bit word at bit 20.
        w64 = 64'h8000_0000_0000_1388;
        lv64 = 1'b1; din64 = w64; sr64 = 1'b1;
        step();
        lv64 = 1'b0; din64 = 64'd0;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("abort bit%0d out", i), 64'(so64), 64'(w64[i]));
            step();
        end
        check("abort bit20 valid", 64'(sv64), 64'd1);
        check("abort bit20 out", 64'(so64), 64'(w64[20]));
        #2;
        rst64 = 1'b0;
        #1;
        idle64("abort async");
        step();
        rst64 = 1'b1;
        step();
        idle64("abort released");
        check("abort cnt", 64'(d64.cnt_r), 64'd0);
        send64("after-abort", 64'd1010);

        // Full-width boundary: 64 ones.
        send64("ones", 64'hFFFF_FFFF_FFFF_FFFF);
        check("ones cnt", 64'(d64.cnt_r), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
